uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
- Receive-side controller placed between the uart_rx serial receiver and the peripheral bus register file.
- Sequences the receiver enable and buffers received frames in a small FIFO.
- Filters BREAK conditions and tracks sticky status: overrun, break and idle-timeout.
- Generates a single level-sensitive interrupt for the CPU.

Parameters:
- PAYLOAD_BITS, 8, data bits per frame; must match uart_rx.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, at least 2.
- TIMEOUT_CYCLES, 4096, clock cycles without a push or pop, with FIFO non-empty, before the timeout flag sets.
- LVL_W, $clog2(FIFO_DEPTH)+1, width of level and threshold fields (derived).

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- cfg_rx_en  in  1  software receive enable.
- cfg_flush  in  1  single-cycle pulse; empties the FIFO.
- cfg_irq_en  in  1  global interrupt enable.
- cfg_irq_lvl  in  LVL_W  FIFO level threshold for the interrupt; 0 disables the level source.
- clr_status  in  1  single-cycle pulse; clears all sticky flags.
- uart_rx_en  out  1  enable driven to uart_rx.
- uart_rx_valid  in  1  single-cycle frame-received strobe from uart_rx.
- uart_rx_break  in  1  qualifies uart_rx_valid as a BREAK (all-zero) frame.
- uart_rx_data  in  PAYLOAD_BITS  frame data from uart_rx.
- rd_req  in  1  pop request; ignored when the FIFO is empty.
- rd_data  out  PAYLOAD_BITS  FIFO head entry; 0 when empty.
- fifo_level  out  LVL_W  current number of stored entries.
- fifo_empty  out  1  fifo_level == 0.
- fifo_full  out  1  fifo_level == FIFO_DEPTH.
- stat_overrun  out  1  sticky: a frame was dropped because the FIFO was full.
- stat_break  out  1  sticky: a BREAK was detected.
- stat_timeout  out  1  sticky: the idle timeout expired.
- irq  out  1  registered interrupt output.

Behaviour:
- Reset values: every output and internal register is 0; FSM in OFF; FIFO storage cleared.
- FSM states, encoded in 2 bits:
  - OFF: entered whenever cfg_rx_en=0, from any state, on the next edge.
  - RUN: entered from OFF when cfg_rx_en=1.
  - BRK: entered from RUN on uart_rx_valid & uart_rx_break.
  - BRK exits to RUN on uart_rx_valid & !uart_rx_break; that frame is pushed normally.
- uart_rx_en is registered and equals (state != OFF): if cfg_rx_en rises at edge n, uart_rx_en is 1 after edge n+1.
- Push condition: uart_rx_valid & !uart_rx_break & state != OFF.
  - Break frames are never pushed.
  - The first break sets stat_break; further breaks while in BRK are dropped silently.
- Pop condition: rd_req & !fifo_empty. rd_data updates on the edge after the pop.
- Push and pop in the same cycle:
  - FIFO non-empty: both complete and the level is unchanged, including when full (no overrun).
  - FIFO empty: push only.
- Overrun: push while full with no pop drops the frame and sets stat_overrun; FIFO contents are unchanged.
- Flush: cfg_flush has priority over push and pop. Pointers and level go to 0 on the next edge; a same-cycle frame is discarded and does not set overrun.
- cfg_rx_en=0 does not flush. Stored data remains readable in OFF.
- Timeout counter:
  - Counts only in RUN/BRK while the FIFO is non-empty.
  - Clears on push, pop, flush, empty FIFO or OFF.
  - Sets stat_timeout when it reaches TIMEOUT_CYCLES-1, then saturates until cleared.
- Sticky flags: clr_status clears all three; a same-cycle set wins over the clear.
- irq is registered (1-cycle latency) and equals cfg_irq_en & (level_src | stat_overrun | stat_break | stat_timeout).
  - level_src = (cfg_irq_lvl != 0) & (fifo_level >= cfg_irq_lvl).
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. fifo_level is a separate LVL_W counter and never exceeds FIFO_DEPTH.
- Asserting resetn mid-frame or mid-FIFO aborts everything immediately; no partial state survives.

Decomposition:
- Shared package uart_pkg holds:
  - the rx_ctrl_state_t enum (OFF, RUN, BRK);
  - the default localparams for PAYLOAD_BITS and TIMEOUT_CYCLES;
  - the status bit-index constants (OVR=0, BRK=1, TMO=2) used by the register file.
- One natural sub-module: uart_rx_fifo.
  - Parameterised storage, pointers, level, flush, and push/pop-same-cycle handling.
  - Reusable later for the TX path.
- The FSM, timeout counter, flags and irq stay in uart_rx_ctrl.

Test Plan:
- Enable then receive: cfg_rx_en=1, send 0x41 then 0x42 via uart_rx_valid.
  - uart_rx_en rises 1 cycle after cfg_rx_en; fifo_level=2; rd_data=0x41.
  - Pop: rd_data=0x42. Pop again: fifo_empty=1 and rd_data=0.
- Overrun: with FIFO_DEPTH=4, push 5 frames (0x10..0x14) with no reads.
  - fifo_full=1, stat_overrun=1; pops return 0x10..0x13.
  - A push and pop in the same cycle while full leaves level=4 with no new overrun.
- Break filtering: send a break strobe, two more break strobes, then 0x55.
  - stat_break=1 and the FSM passes through BRK; only 0x55 is stored (level=1); back in RUN.
- Timeout and irq: TIMEOUT_CYCLES=16, cfg_irq_lvl=0, cfg_irq_en=1, push one frame, then idle.
  - stat_timeout sets after 16 cycles; irq rises 1 cycle later.
  - clr_status drops irq after 1 cycle (the frame is still present but the level source is disabled).
- Flush and disable: push 3 frames, then pulse cfg_flush coincident with uart_rx_valid 0x99.
  - Level=0 and no overrun.
  - cfg_rx_en=0: uart_rx_en=0 next cycle; a later uart_rx_valid is ignored.
- Async reset mid-operation: assert resetn low between clock edges with level=2 and flags set.
  - All outputs are 0 immediately, before the next edge; FSM returns to OFF.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared types and constants for the UART receive path
// Rev 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        ST_OFF = 2'd0,
        ST_RUN = 2'd1,
        ST_BRK = 2'd2
    } rx_ctrl_state_t;

    localparam int C_PAYLOAD_BITS   = 8;
    localparam int C_TIMEOUT_CYCLES = 4096;

    // Bit positions of the sticky status flags as seen by the register file
    localparam int C_STAT_OVR = 0;
    localparam int C_STAT_BRK = 1;
    localparam int C_STAT_TMO = 2;

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// uart_rx_fifo : small synchronous FIFO with flush and drop-on-full reporting
// Rev 1.0
// ============================================================================
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [LVL_W-1:0] level_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             drop_o
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] C_DEPTH = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [LVL_W-1:0] level_q;
    logic             w_pop;
    logic             w_push;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == C_DEPTH);
    assign level_o = level_q;
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

    // A pop frees the slot the same-cycle push needs, so full+pop still accepts
    assign w_pop  = pop_i & ~empty_o & ~flush_i;
    assign w_push = push_i & (~full_o | w_pop) & ~flush_i;
    assign drop_o = push_i & full_o & ~w_pop & ~flush_i;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (w_push) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= wptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            level_q <= level_q + LVL_W'(w_push) - LVL_W'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// uart_rx_ctrl : receiver enable sequencing, RX FIFO, sticky status and irq
// Rev 1.0
// ============================================================================
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int PAYLOAD_BITS   = C_PAYLOAD_BITS,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = C_TIMEOUT_CYCLES,
    parameter int LVL_W          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    cfg_rx_en,
    input  logic                    cfg_flush,
    input  logic                    cfg_irq_en,
    input  logic [LVL_W-1:0]        cfg_irq_lvl,
    input  logic                    clr_status,
    output logic                    uart_rx_en,
    input  logic                    uart_rx_valid,
    input  logic                    uart_rx_break,
    input  logic [PAYLOAD_BITS-1:0] uart_rx_data,
    input  logic                    rd_req,
    output logic [PAYLOAD_BITS-1:0] rd_data,
    output logic [LVL_W-1:0]        fifo_level,
    output logic                    fifo_empty,
    output logic                    fifo_full,
    output logic                    stat_overrun,
    output logic                    stat_break,
    output logic                    stat_timeout,
    output logic                    irq
);

    localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_PRE = CNT_W'(TIMEOUT_CYCLES - 2);

    rx_ctrl_state_t   state_q, state_d;
    logic             uart_rx_en_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       stat_q, stat_d;
    logic             irq_q, irq_d;

    logic             w_on;
    logic             w_push_req;
    logic             w_pop_req;
    logic             w_drop;
    logic             w_idle;
    logic [2:0]       w_set;

    assign w_on       = (state_q != ST_OFF);
    assign w_push_req = uart_rx_valid & ~uart_rx_break & w_on;
    assign w_pop_req  = rd_req & ~fifo_empty;

    uart_rx_fifo #(
        .WIDTH (PAYLOAD_BITS),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .flush_i (cfg_flush),
        .push_i  (w_push_req),
        .pop_i   (rd_req),
        .wdata_i (uart_rx_data),
        .rdata_o (rd_data),
        .level_o (fifo_level),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .drop_o  (w_drop)
    );

    always_comb begin
        state_d = state_q;
        if (!cfg_rx_en) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF:  state_d = ST_RUN;
                ST_RUN:  if (uart_rx_valid && uart_rx_break)  state_d = ST_BRK;
                ST_BRK:  if (uart_rx_valid && !uart_rx_break) state_d = ST_RUN;
                default: state_d = ST_OFF;
            endcase
        end
    end

    // The timeout flag fires once on reaching the limit; the saturated count
    // then holds so a clear is not immediately undone.
    assign w_idle = w_on & ~fifo_empty & ~w_push_req & ~w_pop_req & ~cfg_flush;

    always_comb begin
        cnt_d = '0;
        if (w_idle) begin
            cnt_d = (cnt_q == C_CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        w_set             = '0;
        w_set[C_STAT_OVR] = w_drop;
        w_set[C_STAT_BRK] = uart_rx_valid & uart_rx_break & (state_q == ST_RUN);
        w_set[C_STAT_TMO] = w_idle & (cnt_q == C_CNT_PRE);
        stat_d            = w_set | (stat_q & {3{~clr_status}});
        irq_d             = cfg_irq_en &
                            (((cfg_irq_lvl != '0) && (fifo_level >= cfg_irq_lvl)) || (|stat_q));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_OFF;
            uart_rx_en_q <= 1'b0;
            cnt_q        <= '0;
            stat_q       <= '0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            uart_rx_en_q <= w_on;
            cnt_q        <= cnt_d;
            stat_q       <= stat_d;
            irq_q        <= irq_d;
        end
    end

    assign uart_rx_en   = uart_rx_en_q;
    assign stat_overrun = stat_q[C_STAT_OVR];
    assign stat_break   = stat_q[C_STAT_BRK];
    assign stat_timeout = stat_q[C_STAT_TMO];
    assign irq          = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_ctrl : directed stimulus, per-cycle model compare, literal pins
// Rev 1.0
// ============================================================================
module tb_uart_rx_ctrl;
    import uart_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          cfg_rx_en = 1'b0;
    logic          cfg_flush = 1'b0;
    logic          cfg_irq_en = 1'b0;
    logic [LW-1:0] cfg_irq_lvl = '0;
    logic          clr_status = 1'b0;
    logic          uart_rx_valid = 1'b0;
    logic          uart_rx_break = 1'b0;
    logic [7:0]    uart_rx_data = '0;
    logic          rd_req = 1'b0;
    logic          uart_rx_en;
    logic [7:0]    rd_data;
    logic [LW-1:0] fifo_level;
    logic          fifo_empty, fifo_full;
    logic          stat_overrun, stat_break, stat_timeout, irq;

    int errs   = 0;
    int checks = 0;

    // Behavioural model state
    logic [7:0] mq[$];
    bit m_on, m_inbrk, m_uen, m_ovr, m_brk, m_tmo, m_irq;
    int m_idle;

    always #5 clk = ~clk;

    uart_rx_ctrl #(
        .PAYLOAD_BITS(8), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .LVL_W(LW)
    ) dut (
        .clk(clk), .resetn(resetn), .cfg_rx_en(cfg_rx_en), .cfg_flush(cfg_flush),
        .cfg_irq_en(cfg_irq_en), .cfg_irq_lvl(cfg_irq_lvl), .clr_status(clr_status),
        .uart_rx_en(uart_rx_en), .uart_rx_valid(uart_rx_valid), .uart_rx_break(uart_rx_break),
        .uart_rx_data(uart_rx_data), .rd_req(rd_req), .rd_data(rd_data),
        .fifo_level(fifo_level), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .stat_overrun(stat_overrun), .stat_break(stat_break), .stat_timeout(stat_timeout),
        .irq(irq)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_on = 0; m_inbrk = 0; m_uen = 0; m_ovr = 0; m_brk = 0; m_tmo = 0; m_irq = 0;
        m_idle = 0;
    endtask

    task automatic model_step();
        int lvl      = mq.size();
        bit pushreq  = uart_rx_valid && !uart_rx_break && m_on;
        bit popreq   = rd_req && (lvl > 0);
        bit set_ovr  = pushreq && (lvl == DEPTH) && !popreq && !cfg_flush;
        bit set_brk  = uart_rx_valid && uart_rx_break && m_on && !m_inbrk;
        bit qual     = m_on && (lvl > 0) && !pushreq && !popreq && !cfg_flush;
        bit set_tmo;
        m_irq = cfg_irq_en && (((cfg_irq_lvl != 0) && (lvl >= int'(cfg_irq_lvl)))
                               || m_ovr || m_brk || m_tmo);
        m_idle  = qual ? m_idle + 1 : 0;
        set_tmo = qual && (m_idle == TMO - 1);
        m_ovr = set_ovr || (m_ovr && !clr_status);
        m_brk = set_brk || (m_brk && !clr_status);
        m_tmo = set_tmo || (m_tmo && !clr_status);
        if (cfg_flush) begin
            mq.delete();
        end else begin
            if (popreq) void'(mq.pop_front());
            if (pushreq && (lvl < DEPTH || popreq)) mq.push_back(uart_rx_data);
        end
        m_uen = m_on;
        if (!cfg_rx_en) begin
            m_on = 0; m_inbrk = 0;
        end else if (!m_on) begin
            m_on = 1;
        end else if (uart_rx_valid) begin
            m_inbrk = uart_rx_break;
        end
    endtask

    initial begin : model_proc
        model_reset();
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) model_reset();
            else         model_step();
        end
    end

    initial begin : compare_proc
        forever begin
            @(negedge clk);
            check("uart_rx_en", int'(uart_rx_en), int'(m_uen));
            check("fifo_level", int'(fifo_level), mq.size());
            check("fifo_empty", int'(fifo_empty), int'(mq.size() == 0));
            check("fifo_full", int'(fifo_full), int'(mq.size() == DEPTH));
            check("rd_data", int'(rd_data), (mq.size() > 0) ? int'(mq[0]) : 0);
            check("stat_overrun", int'(stat_overrun), int'(m_ovr));
            check("stat_break", int'(stat_break), int'(m_brk));
            check("stat_timeout", int'(stat_timeout), int'(m_tmo));
            check("irq", int'(irq), int'(m_irq));
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] d);
        uart_rx_valid = 1; uart_rx_break = 0; uart_rx_data = d;
        cyc();
        uart_rx_valid = 0; uart_rx_data = '0;
    endtask

    task automatic brk_frame();
        uart_rx_valid = 1; uart_rx_break = 1; uart_rx_data = '0;
        cyc();
        uart_rx_valid = 0; uart_rx_break = 0;
    endtask

    task automatic pop();
        rd_req = 1;
        cyc();
        rd_req = 0;
    endtask

    task automatic clear_flags();
        clr_status = 1;
        cyc();
        clr_status = 0;
    endtask

    initial begin : stim
        repeat (3) cyc();
        resetn = 1;
        cyc();
        check("rst_level", int'(fifo_level), 0);
        check("rst_empty", int'(fifo_empty), 1);
        check("rst_rx_en", int'(uart_rx_en), 0);
        check("rst_irq", int'(irq), 0);

        // Enable then receive
        cfg_rx_en = 1;
        cyc();
        check("en_lag", int'(uart_rx_en), 0);
        cyc();
        check("en_up", int'(uart_rx_en), 1);
        frame(8'h41);
        frame(8'h42);
        check("rx2_level", int'(fifo_level), 2);
        check("rx2_head", int'(rd_data), 8'h41);
        pop();
        check("pop1_head", int'(rd_data), 8'h42);
        pop();
        check("pop2_empty", int'(fifo_empty), 1);
        check("pop2_data", int'(rd_data), 0);

        // Overrun
        for (int i = 0; i < 5; i++) frame(8'(8'h10 + i));
        check("ovr_full", int'(fifo_full), 1);
        check("ovr_flag", int'(stat_overrun), 1);
        check("ovr_head", int'(rd_data), 8'h10);
        clear_flags();
        check("ovr_clr", int'(stat_overrun), 0);
        uart_rx_valid = 1; uart_rx_data = 8'h20; rd_req = 1;
        cyc();
        uart_rx_valid = 0; rd_req = 0;
        check("pp_full_level", int'(fifo_level), 4);
        check("pp_full_noovr", int'(stat_overrun), 0);
        check("pp_head", int'(rd_data), 8'h11);
        repeat (4) pop();
        check("ovr_drain", int'(fifo_empty), 1);

        // Break filtering
        brk_frame();
        check("brk_flag", int'(stat_break), 1);
        check("brk_state", int'(dut.state_q), int'(ST_BRK));
        brk_frame();
        brk_frame();
        check("brk_nopush", int'(fifo_level), 0);
        frame(8'h55);
        check("brk_level", int'(fifo_level), 1);
        check("brk_data", int'(rd_data), 8'h55);
        check("brk_run", int'(dut.state_q), int'(ST_RUN));
        pop();

        // Timeout and irq
        clear_flags();
        cfg_irq_en = 1;
        cfg_irq_lvl = '0;
        frame(8'h77);
        repeat (14) cyc();
        check("tmo_early", int'(stat_timeout), 0);
        cyc();
        check("tmo_set", int'(stat_timeout), 1);
        check("tmo_irq_lag", int'(irq), 0);
        cyc();
        check("tmo_irq", int'(irq), 1);
        clear_flags();
        check("tmo_clr", int'(stat_timeout), 0);
        cyc();
        check("tmo_irq_drop", int'(irq), 0);
        check("tmo_frame_kept", int'(fifo_level), 1);
        pop();

        // Flush and disable
        frame(8'h01); frame(8'h02); frame(8'h03);
        check("fl_pre", int'(fifo_level), 3);
        cfg_flush = 1; uart_rx_valid = 1; uart_rx_data = 8'h99;
        cyc();
        cfg_flush = 0; uart_rx_valid = 0;
        check("fl_level", int'(fifo_level), 0);
        check("fl_noovr", int'(stat_overrun), 0);
        frame(8'h33);
        cfg_rx_en = 0;
        cyc();
        cyc();
        check("dis_rx_en", int'(uart_rx_en), 0);
        frame(8'h5A);
        check("dis_ignored", int'(fifo_level), 1);
        check("dis_readable", int'(rd_data), 8'h33);

        // Level irq, then async reset mid-operation
        cfg_rx_en = 1;
        cfg_irq_lvl = LW'(2);
        repeat (2) cyc();
        pop();
        frame(8'hA1);
        frame(8'hA2);
        cyc();
        check("lvl_irq", int'(irq), 1);
        brk_frame();
        check("pre_rst_brk", int'(stat_break), 1);
        #2 resetn = 0;
        #1;
        check("arst_level", int'(fifo_level), 0);
        check("arst_empty", int'(fifo_empty), 1);
        check("arst_data", int'(rd_data), 0);
        check("arst_rx_en", int'(uart_rx_en), 0);
        check("arst_flags", int'({stat_overrun, stat_break, stat_timeout}), 0);
        check("arst_irq", int'(irq), 0);
        check("arst_state", int'(dut.state_q), int'(ST_OFF));
        repeat (2) cyc();
        resetn = 1;
        cyc();
        check("post_rst_rx_en", int'(uart_rx_en), 0);
        repeat (3) cyc();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire
